// File: rtl/registerfile_sb.sv
// Register file with two registered read ports, one writeback port and a
// per-register pending scoreboard (issue sets, writeback clears).
//
// Handshake: there is no backpressure. rd_en, wr_en and iss_en are single-cycle
// strobes sampled on each rising Clk edge, and all three are independent.
// rd_valid is high for exactly the cycle after an edge that sampled rd_en.
// A, B, pend_a and pend_b keep their values while rd_en is low.
module registerfile_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic              rd_valid,
  output logic              pend_a,
  output logic              pend_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_clr;
  logic [DEPTH-1:0] pend_d;
  logic             wr_ok;
  logic             iss_ok;
  logic [WIDTH-1:0] rd_a_d;
  logic [WIDTH-1:0] rd_b_d;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + (ADDR_W+1)'(v[i]);
    end
    return c;
  endfunction

  // With ZERO_REG, register 0 can neither be written nor issued.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Clear first, then set: a same-cycle issue wins over the writeback clear.
  always_comb begin
    pend_clr = pend_q;
    if (wr_en) begin
      pend_clr[wr_addr] = 1'b0;
    end
    pend_d = pend_clr;
    if (iss_ok) begin
      pend_d[iss_addr] = 1'b1;
    end
  end

  // Write-first bypass; register 0 stays zero under ZERO_REG because wr_ok
  // is never set for it and the storage is only cleared by reset.
  always_comb begin
    rd_a_d = regs[addr_a];
    rd_b_d = regs[addr_b];
    if (wr_ok && (wr_addr == addr_a)) begin
      rd_a_d = wr_data;
    end
    if (wr_ok && (wr_addr == addr_b)) begin
      rd_b_d = wr_data;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      pend_cnt <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_cnt <= popcount(pend_d);
    end
  end

  // pend_x samples the post-clear, pre-issue view of the scoreboard.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      A        <= '0;
      B        <= '0;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        A      <= rd_a_d;
        B      <= rd_b_d;
        pend_a <= pend_clr[addr_a];
        pend_b <= pend_clr[addr_b];
      end
    end
  end

endmodule

// File: tb/tb_registerfile_sb.sv
// Bench for registerfile_sb: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share the stimulus and are compared against an array model.
module tb_registerfile_sb;

  logic        Clk;
  logic        reset_n;
  logic        rd_en;
  logic [3:0]  addr_a;
  logic [3:0]  addr_b;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [3:0]  iss_addr;

  logic [31:0] a_o [2];
  logic [31:0] b_o [2];
  logic        valid_o [2];
  logic        pa_o [2];
  logic        pb_o [2];
  logic [4:0]  cnt_o [2];

  registerfile_sb #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0)) u_dut0 (
    .Clk(Clk), .reset_n(reset_n), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .A(a_o[0]), .B(b_o[0]), .rd_valid(valid_o[0]),
    .pend_a(pa_o[0]), .pend_b(pb_o[0]), .pend_cnt(cnt_o[0])
  );

  registerfile_sb #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1)) u_dut1 (
    .Clk(Clk), .reset_n(reset_n), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .A(a_o[1]), .B(b_o[1]), .rd_valid(valid_o[1]),
    .pend_a(pa_o[1]), .pend_b(pb_o[1]), .pend_cnt(cnt_o[1])
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // reference model: register contents and pending flags per instance
  logic [31:0] m [2][16];
  bit          p [2][16];
  logic [31:0] ea [2];
  logic [31:0] eb [2];
  bit          epa [2];
  bit          epb [2];
  bit          ev [2];
  int          ecnt [2];

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < 16; r++) begin
        m[z][r] = '0;
        p[z][r] = 1'b0;
      end
      ea[z] = '0; eb[z] = '0; epa[z] = 1'b0; epb[z] = 1'b0; ev[z] = 1'b0; ecnt[z] = 0;
    end
  endtask

  // Apply one clock edge of architectural behaviour to the model.
  task automatic model_step(input bit rd, input int aa, input int ab, input bit we,
                            input int wa, input logic [31:0] wd, input bit ie, input int ia);
    for (int z = 0; z < 2; z++) begin
      bit wr_blocked;
      wr_blocked = (z == 1) && (wa == 0);
      ev[z] = rd;
      if (rd) begin
        ea[z]  = (we && !wr_blocked && wa == aa) ? wd : m[z][aa];
        eb[z]  = (we && !wr_blocked && wa == ab) ? wd : m[z][ab];
        epa[z] = p[z][aa] && !(we && wa == aa);
        epb[z] = p[z][ab] && !(we && wa == ab);
      end
      if (we && !wr_blocked) m[z][wa] = wd;
      if (we) p[z][wa] = 1'b0;
      if (ie && !(z == 1 && ia == 0)) p[z][ia] = 1'b1;
      ecnt[z] = 0;
      for (int r = 0; r < 16; r++) ecnt[z] += int'(p[z][r]);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int z = 0; z < 2; z++) begin
      check($sformatf("%s_z%0d_A", tag, z), 64'(a_o[z]), 64'(ea[z]));
      check($sformatf("%s_z%0d_B", tag, z), 64'(b_o[z]), 64'(eb[z]));
      check($sformatf("%s_z%0d_valid", tag, z), 64'(valid_o[z]), 64'(ev[z]));
      check($sformatf("%s_z%0d_pend_a", tag, z), 64'(pa_o[z]), 64'(epa[z]));
      check($sformatf("%s_z%0d_pend_b", tag, z), 64'(pb_o[z]), 64'(epb[z]));
      check($sformatf("%s_z%0d_cnt", tag, z), 64'(cnt_o[z]), 64'(ecnt[z]));
    end
  endtask

  // driver: one cycle of stimulus, then check both instances after the edge
  task automatic cycle(input string tag, input bit rd, input int aa, input int ab,
                       input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia);
    rd_en = rd; addr_a = 4'(aa); addr_b = 4'(ab);
    wr_en = we; wr_addr = 4'(wa); wr_data = wd;
    iss_en = ie; iss_addr = 4'(ia);
    model_step(rd, aa, ab, we, wa, wd, ie, ia);
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    rd_en = 0; addr_a = 0; addr_b = 0; wr_en = 0; wr_addr = 0;
    wr_data = 0; iss_en = 0; iss_addr = 0;
  endtask

  int cnt_before;

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all("reset");
    reset_n = 1'b1;

    // read after reset
    cycle("rd_clean", 1, 3, 15, 0, 0, 0, 0, 0);
    check("rd_clean_valid", 64'(valid_o[0]), 64'd1);
    check("rd_clean_A", 64'(a_o[0]), 64'd0);
    cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_valid", 64'(valid_o[0]), 64'd0);

    // write then read, then same-cycle write-first bypass
    cycle("wr5", 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    cycle("rd5", 1, 5, 0, 0, 0, 0, 0, 0);
    check("rd5_A", 64'(a_o[0]), 64'hDEADBEEF);
    cycle("byp5", 1, 5, 5, 1, 5, 32'h12345678, 0, 0);
    check("byp5_A", 64'(a_o[0]), 64'h12345678);
    check("byp5_B", 64'(b_o[1]), 64'h12345678);

    // scoreboard issue / writeback
    cycle("iss7", 0, 0, 0, 0, 0, 0, 1, 7);
    cycle("iss9", 0, 0, 0, 0, 0, 0, 1, 9);
    check("iss_cnt2", 64'(cnt_o[0]), 64'd2);
    cycle("rdp7", 1, 7, 9, 0, 0, 0, 0, 0);
    check("rdp7_pend_a", 64'(pa_o[0]), 64'd1);
    cycle("wb7", 1, 7, 9, 1, 7, 32'hCAFE0007, 0, 0);
    check("wb7_pend_a", 64'(pa_o[0]), 64'd0);
    check("wb7_A", 64'(a_o[0]), 64'hCAFE0007);
    check("wb7_cnt", 64'(cnt_o[0]), 64'd1);

    // issue and writeback to the same register: write lands, bit stays set
    cycle("isswr4", 0, 0, 0, 1, 4, 32'h44444444, 1, 4);
    check("isswr4_cnt", 64'(cnt_o[0]), 64'd2);
    cycle("rd4", 1, 4, 4, 0, 0, 0, 0, 0);
    check("rd4_A", 64'(a_o[0]), 64'h44444444);
    check("rd4_pend", 64'(pa_o[0]), 64'd1);

    // register 0 behaviour with and without ZERO_REG
    cnt_before = int'(cnt_o[1]);
    cycle("wr0", 1, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    check("wr0_byp_z1", 64'(a_o[1]), 64'd0);
    check("wr0_byp_z0", 64'(a_o[0]), 64'hFFFFFFFF);
    cycle("iss0", 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("rd0", 1, 0, 0, 0, 0, 0, 0, 0);
    check("rd0_A_z1", 64'(a_o[1]), 64'd0);
    check("rd0_pend_z1", 64'(pa_o[1]), 64'd0);
    check("rd0_cnt_z1", 64'(cnt_o[1]), 64'(cnt_before));
    check("rd0_pend_z0", 64'(pa_o[0]), 64'd1);

    // asynchronous reset between edges, with traffic held during reset
    cycle("wr2", 0, 0, 0, 1, 2, 32'h22222222, 0, 0);
    cycle("iss3", 1, 2, 3, 0, 0, 0, 1, 3);
    #3;
    rd_en = 1; addr_a = 2; wr_en = 1; wr_addr = 2; wr_data = 32'h99999999;
    iss_en = 1; iss_addr = 6;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    @(posedge Clk);
    #1;
    compare_all("rst_held");
    idle_inputs();
    reset_n = 1'b1;
    cycle("post_rst", 1, 2, 3, 0, 0, 0, 0, 0);
    check("post_rst_A", 64'(a_o[0]), 64'd0);
    check("post_rst_cnt", 64'(cnt_o[0]), 64'd0);

    // randomized traffic; small address window half the time forces collisions
    for (int i = 0; i < 600; i++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 1) ? 3 : 15;
      cycle("rand", bit'($urandom_range(0, 1)), int'($urandom_range(0, hi)),
            int'($urandom_range(0, hi)), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, hi)), $urandom, bit'($urandom_range(0, 1)),
            int'($urandom_range(0, hi)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/registerfile_sb.md
REGISTERFILE_SB -- requirements
Module: registerfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 0, meaning 1 = register 0 hardwired to zero.
REQ-004 SHALL use exactly one clock and an asynchronous, active-low reset.
REQ-005 Port: Clk  input  1  rising-edge clock.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: rd_en  input  1  read strobe for both read ports.
REQ-008 Port: addr_a  input  ADDR_W  read port A address.
REQ-009 Port: addr_b  input  ADDR_W  read port B address.
REQ-010 Port: wr_en  input  1  writeback strobe.
REQ-011 Port: wr_addr  input  ADDR_W  writeback address.
REQ-012 Port: wr_data  input  WIDTH  writeback data.
REQ-013 Port: iss_en  input  1  issue strobe; marks iss_addr pending.
REQ-014 Port: iss_addr  input  ADDR_W  destination register being issued.
REQ-015 Port: A  output  WIDTH  registered read data, port A.
REQ-016 Port: B  output  WIDTH  registered read data, port B.
REQ-017 Port: rd_valid  output  1  A/B/pend flags updated this cycle.
REQ-018 Port: pend_a  output  1  addr_a was pending at read time.
REQ-019 Port: pend_b  output  1  addr_b was pending at read time.
REQ-020 Port: pend_cnt  output  ADDR_W+1  number of pending registers.

Function
REQ-021 Read, write and issue SHALL be independent; all three may occur in the same cycle.
REQ-022 Read latency SHALL be 1 cycle: rd_en at edge N -> A, B, pend_a, pend_b, rd_valid=1 after edge N; rd_valid=0 after any edge without rd_en.
REQ-023 A, B, pend_a, pend_b SHALL hold their values while rd_en=0.
REQ-024 wr_en SHALL write wr_data into wr_addr at the rising edge.
REQ-025 Write-first bypass: rd_en and wr_en in the same cycle with addr_x == wr_addr SHALL return wr_data on that port.
REQ-026 Scoreboard: one pending bit per register; iss_en sets bit[iss_addr], wr_en clears bit[wr_addr].
REQ-027 iss_en and wr_en to the same address in the same cycle SHALL leave the bit set (new issue wins); data is still written.
REQ-028 pend_x SHALL reflect the bit after the same-cycle write clear but before the same-cycle issue set.
REQ-029 wr_en to a non-pending register SHALL write normally, with no error and no scoreboard change.
REQ-030 iss_en to an already-pending register SHALL keep it pending, and pend_cnt SHALL not change.
REQ-031 pend_cnt SHALL equal the population count of pending bits after each edge, range 0..DEPTH.
REQ-032 With ZERO_REG=1: register 0 SHALL read 0 (including via bypass), ignore writes, never become pending, and pend_a/pend_b for address 0 SHALL be 0.

Reset
REQ-033 reset_n low SHALL asynchronously clear all registers, pending bits, A, B, rd_valid, pend_a, pend_b and pend_cnt to 0.
REQ-034 Reset asserted mid-operation SHALL discard any same-cycle write, issue or read; the first edge after release SHALL behave as from a clean state.

Verification
REQ-035 Reset, then rd_en with addr_a=3, addr_b=15 -> A=0, B=0, pend_a=0, pend_b=0, rd_valid=1 one cycle later.
REQ-036 wr_en addr 5 data 0xDEADBEEF, next cycle rd_en addr_a=5 -> A=0xDEADBEEF; a same-cycle write+read of addr 5 with 0x12345678 -> A=0x12345678.
REQ-037 iss_en addr 7, iss_en addr 9 -> pend_cnt=2; rd addr_a=7 -> pend_a=1; wr_en addr 7 with a same-cycle read of 7 -> pend_a=0, A=wr_data, pend_cnt=1.
REQ-038 iss_en and wr_en both addr 4 in one cycle -> register 4 written, still pending, pend_cnt increments by 1.
REQ-039 ZERO_REG=1: wr_en addr 0 data 0xFFFFFFFF, iss_en addr 0, then read addr 0 -> A=0, pend_a=0, pend_cnt unchanged.
REQ-040 After writing addr 2 and issuing addr 3, pull reset_n low between edges -> all outputs 0 immediately; after release, read of 2 returns 0 and pend_cnt=0.
